// File: rtl/divider_ctrl.sv
// divider_ctrl: programmable clock-enable divider with a glitch-free
// reconfiguration handshake.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   enable     request to run the divider
//   cfg_valid  a new {cfg_div, cfg_duty} configuration is offered
//   cfg_div    offered divide ratio N (legal 2..15)
//   cfg_duty   offered duty mode (0 = one-cycle pulse, 1 = floor(N/2) high)
//   cfg_ready  configuration can be taken this cycle (low while one is pending)
//   q          divided output
//   tick       one-cycle strobe at the first cycle of every period
//   running    divider active
//   err        sticky: an offered configuration was rejected (N < 2)
module divider_ctrl #(
  parameter int unsigned DEFAULT_DIV  = 3,
  parameter bit          DEFAULT_DUTY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_div,
  input  logic       cfg_duty,
  output logic       cfg_ready,
  output logic       q,
  output logic       tick,
  output logic       running,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  typedef struct packed {
    logic [3:0] div;
    logic       duty;
  } cfg_t;

  localparam cfg_t CFG_RST = '{div: 4'(DEFAULT_DIV), duty: DEFAULT_DUTY};

  state_t     state, state_nxt;
  cfg_t       cur, cur_nxt, pend, pend_nxt;
  cfg_t       offer;
  logic [3:0] cnt, cnt_nxt;
  logic       err_nxt;
  logic       xfer, legal, last;

  assign offer = '{div: cfg_div, duty: cfg_duty};
  assign xfer  = cfg_valid && cfg_ready;
  assign legal = (cfg_div >= 4'd2);
  assign last  = (cnt == cur.div - 4'd1);

  // State register (FSM state plus the datapath it steers)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cur   <= CFG_RST;
      pend  <= CFG_RST;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cur   <= cur_nxt;
      pend  <= pend_nxt;
      err   <= err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur;
    pend_nxt  = pend;
    // A rejected offer is still consumed; it only raises the sticky flag.
    err_nxt   = err || (xfer && !legal);
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (xfer && legal) cur_nxt = offer;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (last) begin
          // Offer landing on the period's final cycle goes straight to the
          // next period: no reason to park it in pend.
          cnt_nxt = '0;
          if (xfer && legal) cur_nxt = offer;
          if (!enable) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (xfer && legal) begin
            pend_nxt  = offer;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (last) begin
          cnt_nxt   = '0;
          cur_nxt   = pend;
          state_nxt = enable ? RUN : IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs, decoded from registered state only
  always_comb begin
    running   = (state == RUN) || (state == PEND);
    cfg_ready = (state != PEND);
    tick      = running && (cnt == 4'd0);
    q         = cur.duty ? (running && (cnt < (cur.div >> 1))) : tick;
  end

endmodule

// File: tb/tb_divider_ctrl.sv
module tb_divider_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_div = 4'd0;
  logic       cfg_duty = 1'b0;
  logic       cfg_ready, q, tick, running, err;

  int n_chk = 0;
  int n_err = 0;

  divider_ctrl #(.DEFAULT_DIV(3), .DEFAULT_DUTY(1'b0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_valid(cfg_valid),
    .cfg_div(cfg_div), .cfg_duty(cfg_duty), .cfg_ready(cfg_ready),
    .q(q), .tick(tick), .running(running), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: period position, active ratio/duty, one parked offer.
  bit      m_act, m_pv, m_err, m_duty, m_pd;
  int      m_pos, m_n, m_pn;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_act = 0; m_pos = 0; m_n = 3; m_duty = 0; m_pv = 0; m_pn = 3; m_pd = 0; m_err = 0;
  endtask

  task automatic check_all();
    bit et, eq;
    et = m_act && (m_pos == 0);
    eq = m_duty ? (m_act && (m_pos < m_n / 2)) : et;
    chk("running",   {3'b0, running},   {3'b0, m_act});
    chk("tick",      {3'b0, tick},      {3'b0, et});
    chk("q",         {3'b0, q},         {3'b0, eq});
    chk("cfg_ready", {3'b0, cfg_ready}, {3'b0, !m_pv});
    chk("err",       {3'b0, err},       {3'b0, m_err});
  endtask

  // Called at a negedge: drive inputs, advance the model one clock, check.
  task automatic step(input bit en, input bit v, input int dv, input bit du);
    bit acc;
    enable = en; cfg_valid = v; cfg_div = 4'(dv); cfg_duty = du;
    acc = 0;
    if (v && !m_pv) begin
      if (dv < 2) m_err = 1; else acc = 1;
    end
    if (!m_act) begin
      if (acc) begin m_n = dv; m_duty = du; end
      if (en) begin m_act = 1; m_pos = 0; end
    end else if (m_pos == m_n - 1) begin
      if (m_pv) begin m_n = m_pn; m_duty = m_pd; m_pv = 0; end
      else if (acc) begin m_n = dv; m_duty = du; end
      m_pos = 0;
      if (!en) m_act = 0;
    end else begin
      m_pos++;
      if (acc) begin m_pv = 1; m_pn = dv; m_pd = du; end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse launched between edges; checks outputs at once.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_running", {3'b0, running},   4'd0);
    chk("rst_q",       {3'b0, q},         4'd0);
    chk("rst_tick",    {3'b0, tick},      4'd0);
    chk("rst_ready",   {3'b0, cfg_ready}, 4'd1);
    chk("rst_err",     {3'b0, err},       4'd0);
    enable = 0; cfg_valid = 0;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    check_all();
  endtask

  initial begin
    logic [4:0] pat;
    int cyc, period;
    m_reset();
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Defaults: N=3 pulse, tick coincides with q
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0);
      chk("tick_eq_q", {3'b0, tick}, {3'b0, q});
    end
    pulse_reset();

    // IDLE config N=5 half duty, then 1,1,0,0,0 pattern
    step(0, 1, 5, 1);
    pat = 5'b00011;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0);
      chk("pat5", {3'b0, q}, {3'b0, pat[i % 5]});
    end
    pulse_reset();

    // Running N=3, offer N=4 at cnt=0: two busy cycles, then 4-cycle periods
    step(1, 0, 0, 0);
    step(1, 1, 4, 0);
    chk("pend_rdy1", {3'b0, cfg_ready}, 4'd0);
    step(1, 0, 0, 0);
    chk("pend_rdy2", {3'b0, cfg_ready}, 4'd0);
    step(1, 0, 0, 0);
    chk("pend_rdy3", {3'b0, cfg_ready}, 4'd1);
    chk("new_tick",  {3'b0, tick},      4'd1);
    period = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      period++;
      if (tick) break;
    end
    chk("period4", 4'(period), 4'd4);

    // Illegal offer: err sticky, period unchanged; later N=6 keeps err
    step(1, 1, 1, 0);
    chk("err_set", {3'b0, err}, 4'd1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 1, 6, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    chk("err_keep", {3'b0, err}, 4'd1);
    pulse_reset();

    // N=4 run, drop enable at cnt=1: two more cycles, then idle
    step(0, 1, 4, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (running) cyc++;
    end
    chk("stop_cyc", 4'(cyc), 4'd2);
    chk("stop_q",   {3'b0, q}, 4'd0);

    // Reset while a config is parked; afterwards period reverts to default
    step(1, 0, 0, 0);
    step(1, 1, 7, 1);
    chk("in_pend", {3'b0, cfg_ready}, 4'd0);
    pulse_reset();
    step(1, 0, 0, 0);
    period = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      period++;
      if (tick) break;
    end
    chk("def_period", 4'(period), 4'd3);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20,
                int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout at %0t: got running want finish", $time);
    $fatal(1);
  end
endmodule
